mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Pipeline stage directly downstream of execute: EX/MEM register, data-memory access FSM and MEM/WB register in one block.
- Captures execute's ALU result, forwarded store data and control.
- Performs aligned 16-bit loads/stores over a variable-latency request/done memory handshake.
- Sources MEM_alu_out and WB_wb_data, which feed back to execute's forwarding muxes, and raises stall to freeze upstream stages while memory is busy.

Parameters:
- REG_BITS, 3: destination register index width.
- TIMEOUT, 255: max cycles a request may wait for dmem_done before err; counter is 8 bits and TIMEOUT must be ≤255.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset; one clock; reset is synchronous and active-high.
- ex_valid  in  1  execute holds a real instruction.
- ex_alu_out  in  16  ALU result; memory address for loads/stores.
- ex_vY  in  16  forwarded store data.
- ex_mem_read  in  1  load.
- ex_mem_write  in  1  store.
- ex_reg_write  in  1  instruction writes the register file.
- ex_rd  in  REG_BITS  destination register.
- ex_halt  in  1  HALT instruction.
- dmem_req  out  1  request held high until done.
- dmem_wr  out  1  1 = write, 0 = read; valid while dmem_req is high.
- dmem_addr  out  16  byte address.
- dmem_wdata  out  16  store data.
- dmem_rdata  in  16  load data; valid in the dmem_done cycle.
- dmem_done  in  1  access complete; may arrive in the same cycle as the request.
- stall  out  1  freeze PC/IF/ID/EX registers this cycle.
- MEM_alu_out  out  16  EX/MEM registered ALU result (forward source).
- MEM_reg_write  out  1  EX/MEM reg_write AND valid (hazard unit).
- MEM_rd  out  REG_BITS  EX/MEM destination.
- WB_wb_data  out  16  MEM/WB write-back data (forward source).
- WB_reg_write  out  1  MEM/WB write enable (valid-qualified).
- WB_rd  out  REG_BITS  MEM/WB destination.
- halted  out  1  sticky; HALT has reached MEM/WB.
- err  out  1  sticky; misaligned access or timeout.

Behaviour:
- Reset: all valid bits 0, data/rd registers 0, FSM IDLE, timeout counter 0, halted=0, err=0, dmem_req=0, stall=0.
- EX/MEM register: loads all ex_* inputs on each edge where stall=0. It holds when stall=1. Bubble = ex_valid 0.
- mem_op = M_valid & (M_mem_read | M_mem_write) & ~M_addr[0] & ~err.
- Misaligned access: M_valid and a mem op with M_alu_out[0]=1 sets err on the next edge. No request is issued; the instruction retires as a bubble.
- dmem_req = mem_op & (state==IDLE | state==BUSY), combinational. dmem_addr = M_alu_out, dmem_wdata = M_vY, dmem_wr = M_mem_write.
- FSM:
  - IDLE: if mem_op & ~dmem_done, go to BUSY; counter := 1. Zero-wait: mem_op & dmem_done stays IDLE and retires.
  - BUSY: if dmem_done, go to IDLE. Otherwise counter++. When counter==TIMEOUT, set err, drop the request, go to IDLE and retire as a bubble.
- stall = mem_op & ~dmem_done, combinational.
- MEM/WB register, every edge:
  - If stall=1: WB valid := 0 (bubble).
  - Otherwise: WB_wb_data := M_mem_read ? dmem_rdata : M_alu_out. WB_rd := M_rd. WB_reg_write := M_valid & M_reg_write & ~(misaligned | timeout).
- halted: set on the edge where a valid HALT moves into MEM/WB; sticky until rst. After halted=1, mem_op is forced 0.
- Latency:
  - Non-memory instruction: 1 cycle EX/MEM → MEM/WB.
  - Load/store: 1 + wait cycles.
- Simultaneous events:
  - rst overrides everything. Reset during BUSY drops dmem_req on the next cycle; the in-flight data is discarded.
  - dmem_done in the same cycle as the first request: no stall.

Decomposition:
- Shared package/header (alongside ops.vh): FSM state encodings MS_IDLE/MS_BUSY, WORD_W=16, default REG_BITS.
- Natural sub-module: mem_fsm (IDLE/BUSY, timeout counter, req/stall/err generation). Pipeline registers stay in mem_stage.

Test Plan:
- ADD bypass: ex_valid=1, alu_out=0x1234, reg_write=1, rd=5 → MEM_alu_out=0x1234 after 1 edge; WB_wb_data=0x1234, WB_rd=5 after 2 edges; stall never high.
- Zero-wait load: addr=0x0040, dmem_done tied 1, rdata=0xBEEF → dmem_req 1 cycle; WB_wb_data=0xBEEF; stall=0.
- 3-wait store: addr=0x0100, vY=0xA5A5, done after 3 cycles → dmem_req/dmem_wr/wdata stable 4 cycles; stall=1 for 3 cycles; EX/MEM holds the next instruction; MEM/WB bubbles, WB_reg_write=0.
- Misaligned load: addr=0x0003 → no dmem_req; err=1 next edge and sticky; WB_reg_write=0.
- Timeout: TIMEOUT=4, dmem_done never asserted → stall for 4 cycles, err=1, dmem_req drops, pipeline resumes.
- Reset in BUSY: rst asserted in 2nd wait cycle → next cycle dmem_req=0, stall=0, all valids 0; a late dmem_done is ignored.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: word width, default register
// index width and the data-memory FSM state encoding.
package mem_stage_pkg;

  localparam int WORD_W           = 16;
  localparam int DEFAULT_REG_BITS = 3;
  localparam int CNT_W            = 8;

  typedef enum logic {
    MS_IDLE = 1'b0,
    MS_BUSY = 1'b1
  } ms_state_t;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/done bus; master is the pipeline stage, slave the memory.
interface mem_stage_if;
  import mem_stage_pkg::*;

  logic              dmem_req;
  logic              dmem_wr;
  logic [WORD_W-1:0] dmem_addr;
  logic [WORD_W-1:0] dmem_wdata;
  logic [WORD_W-1:0] dmem_rdata;
  logic              dmem_done;

  modport master (
    output dmem_req, dmem_wr, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_done
  );

  modport slave (
    input  dmem_req, dmem_wr, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_done
  );

endinterface

// File: rtl/mem_stage_fsm.sv
// Data-memory access sequencer: IDLE/BUSY state, wait-cycle counter,
// request/stall generation and the sticky error flag.
module mem_fsm
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_mem_op,
  input  logic i_misaligned,
  input  logic i_done,
  output logic o_req,
  output logic o_stall,
  output logic o_timeout,
  output logic o_err
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  ms_state_t        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;
  logic             w_timeout;

  // The timeout cycle neither requests nor stalls, so the stuck access
  // leaves EX/MEM on this edge and retires as a bubble.
  assign w_timeout = (r_state == MS_BUSY) && i_mem_op && !i_done && (r_cnt == TIMEOUT_CNT);
  assign o_req     = i_mem_op && !w_timeout;
  assign o_stall   = i_mem_op && !i_done && !w_timeout;
  assign o_timeout = w_timeout;
  assign o_err     = r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= MS_IDLE;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      if (i_misaligned) begin
        r_err <= 1'b1;
      end
      case (r_state)
        MS_IDLE: begin
          if (i_mem_op && !i_done) begin
            r_state <= MS_BUSY;
            r_cnt   <= CNT_W'(1);
          end
        end
        MS_BUSY: begin
          if (i_done || !i_mem_op) begin
            r_state <= MS_IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == TIMEOUT_CNT) begin
            r_err   <= 1'b1;
            r_state <= MS_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= MS_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX/MEM register, data-memory access sequencing and the
// MEM/WB register that feeds write-back and execute's forwarding paths.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int REG_BITS = DEFAULT_REG_BITS,
  parameter int TIMEOUT  = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ex_valid,
  input  logic [WORD_W-1:0]   ex_alu_out,
  input  logic [WORD_W-1:0]   ex_vY,
  input  logic                ex_mem_read,
  input  logic                ex_mem_write,
  input  logic                ex_reg_write,
  input  logic [REG_BITS-1:0] ex_rd,
  input  logic                ex_halt,
  mem_stage_if.master         mem_bus,
  output logic                stall,
  output logic [WORD_W-1:0]   MEM_alu_out,
  output logic                MEM_reg_write,
  output logic [REG_BITS-1:0] MEM_rd,
  output logic [WORD_W-1:0]   WB_wb_data,
  output logic                WB_reg_write,
  output logic [REG_BITS-1:0] WB_rd,
  output logic                halted,
  output logic                err
);

  logic                r_m_valid;
  logic                r_m_mem_read;
  logic                r_m_mem_write;
  logic                r_m_reg_write;
  logic                r_m_halt;
  logic [WORD_W-1:0]   r_m_alu_out;
  logic [WORD_W-1:0]   r_m_vy;
  logic [REG_BITS-1:0] r_m_rd;

  logic [WORD_W-1:0]   r_wb_data;
  logic [REG_BITS-1:0] r_wb_rd;
  logic                r_wb_reg_write;
  logic                r_halted;

  logic w_mem_access;
  logic w_misaligned;
  logic w_mem_op;
  logic w_stall;
  logic w_timeout;
  logic w_err;
  logic w_req;

  // Once err or halted is set, memory instructions flow through without touching memory.
  assign w_mem_access = r_m_valid && (r_m_mem_read || r_m_mem_write);
  assign w_misaligned = w_mem_access && r_m_alu_out[0];
  assign w_mem_op     = w_mem_access && !r_m_alu_out[0] && !w_err && !r_halted;

  mem_fsm #(
    .TIMEOUT(TIMEOUT)
  ) u_fsm (
    .clk         (clk),
    .rst         (rst),
    .i_mem_op    (w_mem_op),
    .i_misaligned(w_misaligned),
    .i_done      (mem_bus.dmem_done),
    .o_req       (w_req),
    .o_stall     (w_stall),
    .o_timeout   (w_timeout),
    .o_err       (w_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_m_valid     <= 1'b0;
      r_m_mem_read  <= 1'b0;
      r_m_mem_write <= 1'b0;
      r_m_reg_write <= 1'b0;
      r_m_halt      <= 1'b0;
      r_m_alu_out   <= '0;
      r_m_vy        <= '0;
      r_m_rd        <= '0;
    end else if (!w_stall) begin
      r_m_valid     <= ex_valid;
      r_m_mem_read  <= ex_mem_read;
      r_m_mem_write <= ex_mem_write;
      r_m_reg_write <= ex_reg_write;
      r_m_halt      <= ex_halt;
      r_m_alu_out   <= ex_alu_out;
      r_m_vy        <= ex_vY;
      r_m_rd        <= ex_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb_data      <= '0;
      r_wb_rd        <= '0;
      r_wb_reg_write <= 1'b0;
      r_halted       <= 1'b0;
    end else if (w_stall) begin
      r_wb_reg_write <= 1'b0;
    end else begin
      r_wb_data      <= r_m_mem_read ? mem_bus.dmem_rdata : r_m_alu_out;
      r_wb_rd        <= r_m_rd;
      r_wb_reg_write <= r_m_valid && r_m_reg_write && !(w_misaligned || w_timeout);
      if (r_m_valid && r_m_halt) begin
        r_halted <= 1'b1;
      end
    end
  end

  assign mem_bus.dmem_req   = w_req;
  assign mem_bus.dmem_wr    = r_m_mem_write;
  assign mem_bus.dmem_addr  = r_m_alu_out;
  assign mem_bus.dmem_wdata = r_m_vy;

  assign stall         = w_stall;
  assign MEM_alu_out   = r_m_alu_out;
  assign MEM_reg_write = r_m_valid && r_m_reg_write;
  assign MEM_rd        = r_m_rd;
  assign WB_wb_data    = r_wb_data;
  assign WB_reg_write  = r_wb_reg_write;
  assign WB_rd         = r_wb_rd;
  assign halted        = r_halted;
  assign err           = w_err;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table, directed multi-cycle
// sequences and a randomized program checked against a program-order model.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int RB    = 3;
  localparam int TO    = 4;
  localparam int NRAND = 400;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, ex_halt;
  logic [15:0]   ex_alu_out, ex_vY;
  logic [RB-1:0] ex_rd;
  logic          stall, MEM_reg_write, WB_reg_write, halted, err;
  logic [15:0]   MEM_alu_out, WB_wb_data;
  logic [RB-1:0] MEM_rd, WB_rd;

  mem_stage_if mb();

  mem_stage #(.REG_BITS(RB), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_alu_out(ex_alu_out), .ex_vY(ex_vY),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
    .ex_rd(ex_rd), .ex_halt(ex_halt), .mem_bus(mb.master), .stall(stall),
    .MEM_alu_out(MEM_alu_out), .MEM_reg_write(MEM_reg_write), .MEM_rd(MEM_rd),
    .WB_wb_data(WB_wb_data), .WB_reg_write(WB_reg_write), .WB_rd(WB_rd),
    .halted(halted), .err(err)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          passes = 0;
  int          slave_lat = 0;
  bit          slave_rand = 1'b0;
  bit          force_done = 1'b0;
  int          s_cnt;
  logic [15:0] smem [64];
  logic [15:0] mmem [64];

  typedef struct {
    logic [RB-1:0] rd;
    logic [15:0]   data;
  } ret_t;
  ret_t exp_q[$];

  typedef struct {
    string         name;
    logic          mrd, mwr, rw;
    logic [15:0]   alu, vy, rdata;
    logic [RB-1:0] rd;
    int            lat;
    int            e_stall, e_req;
    logic          e_we;
    logic [15:0]   e_data;
    logic          e_err, e_store;
  } vec_t;
  vec_t vecs[8];

  // Memory slave: responds lat cycles after the request rises (lat<0: never).
  initial begin
    mb.dmem_done  = 1'b0;
    mb.dmem_rdata = 16'h0;
    s_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst || !mb.dmem_req) begin
        mb.dmem_done = force_done;
        s_cnt = 0;
      end else if (slave_lat >= 0 && s_cnt == slave_lat) begin
        mb.dmem_done = 1'b1;
        if (mb.dmem_wr) smem[mb.dmem_addr[6:1]] = mb.dmem_wdata;
        else            mb.dmem_rdata = smem[mb.dmem_addr[6:1]];
        s_cnt = 0;
        if (slave_rand) slave_lat = int'($urandom_range(0, 3));
      end else begin
        mb.dmem_done = 1'b0;
        s_cnt++;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act === expv) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
  endtask

  task automatic drive_ex(input logic v, input logic mrd, input logic mwr, input logic rw,
                          input logic hlt, input logic [15:0] alu, input logic [15:0] vy,
                          input logic [RB-1:0] rd);
    ex_valid = v; ex_mem_read = mrd; ex_mem_write = mwr; ex_reg_write = rw;
    ex_halt = hlt; ex_alu_out = alu; ex_vY = vy; ex_rd = rd;
  endtask

  task automatic bubble();
    drive_ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 3'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1; force_done = 1'b0; slave_rand = 1'b0;
    bubble();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  function automatic vec_t mkv(input string nm, input logic mrd, input logic mwr, input logic rw,
                               input logic [15:0] alu, input logic [15:0] vy, input logic [15:0] rdata,
                               input logic [RB-1:0] rd, input int lat, input int es, input int er,
                               input logic ewe, input logic [15:0] edata, input logic eerr,
                               input logic estore);
    vec_t v;
    v.name = nm; v.mrd = mrd; v.mwr = mwr; v.rw = rw; v.alu = alu; v.vy = vy;
    v.rdata = rdata; v.rd = rd; v.lat = lat; v.e_stall = es; v.e_req = er;
    v.e_we = ewe; v.e_data = edata; v.e_err = eerr; v.e_store = estore;
    return v;
  endfunction

  // One instruction followed by bubbles: count stall/request cycles, then check retirement.
  task automatic apply_vec(input vec_t v);
    int st, rq;
    bit fin;
    do_reset();
    slave_lat = v.lat;
    smem[v.alu[6:1]] = v.rdata;
    drive_ex(1'b1, v.mrd, v.mwr, v.rw, 1'b0, v.alu, v.vy, v.rd);
    @(posedge clk); #1;
    bubble();
    st = 0; rq = 0; fin = 1'b0;
    for (int c = 0; c < 20 && !fin; c++) begin
      @(negedge clk); #1;
      if (mb.dmem_req) rq++;
      if (stall) st++;
      else fin = 1'b1;
    end
    chk({v.name, " retired"}, 32'(fin), 32'd1);
    chk({v.name, " stall_cycles"}, 32'(st), 32'(v.e_stall));
    chk({v.name, " req_cycles"}, 32'(rq), 32'(v.e_req));
    @(posedge clk); #1;
    chk({v.name, " WB_reg_write"}, 32'(WB_reg_write), 32'(v.e_we));
    if (v.e_we) begin
      chk({v.name, " WB_wb_data"}, 32'(WB_wb_data), 32'(v.e_data));
      chk({v.name, " WB_rd"}, 32'(WB_rd), 32'(v.rd));
    end
    chk({v.name, " err"}, 32'(err), 32'(v.e_err));
    if (v.e_store) chk({v.name, " mem_written"}, 32'(smem[v.alu[6:1]]), 32'(v.vy));
  endtask

  task automatic gen_drive();
    int            kind;
    logic [5:0]    idx;
    logic [15:0]   val, addr;
    logic [RB-1:0] rd;
    ret_t          r;
    kind = int'($urandom_range(0, 9));
    idx  = 6'($urandom);
    val  = 16'($urandom);
    rd   = RB'($urandom);
    addr = {9'h0, idx, 1'b0};
    if (kind < 3) begin
      drive_ex(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, val, 16'h0, rd);
      r.rd = rd; r.data = val; exp_q.push_back(r);
    end else if (kind < 6) begin
      drive_ex(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, addr, 16'h0, rd);
      r.rd = rd; r.data = mmem[idx]; exp_q.push_back(r);
    end else if (kind < 8) begin
      drive_ex(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, addr, val, rd);
      mmem[idx] = val;
    end else begin
      bubble();
    end
  endtask

  initial begin
    int   issued;
    bit   consumed;
    ret_t r;

    // Reset state
    do_reset();
    chk("reset dmem_req", 32'(mb.dmem_req), 32'd0);
    chk("reset stall", 32'(stall), 32'd0);
    chk("reset MEM_reg_write", 32'(MEM_reg_write), 32'd0);
    chk("reset MEM_alu_out", 32'(MEM_alu_out), 32'd0);
    chk("reset WB_reg_write", 32'(WB_reg_write), 32'd0);
    chk("reset WB_wb_data", 32'(WB_wb_data), 32'd0);
    chk("reset halted", 32'(halted), 32'd0);
    chk("reset err", 32'(err), 32'd0);

    // Vector table: name mrd mwr rw alu vy rdata rd lat | stall req we data err store
    vecs[0] = mkv("add",       1'b0, 1'b0, 1'b1, 16'h1234, 16'h0,    16'h0,    3'd5, 0,  0, 0, 1'b1, 16'h1234, 1'b0, 1'b0);
    vecs[1] = mkv("ld0wait",   1'b1, 1'b0, 1'b1, 16'h0040, 16'h0,    16'hBEEF, 3'd3, 0,  0, 1, 1'b1, 16'hBEEF, 1'b0, 1'b0);
    vecs[2] = mkv("st3wait",   1'b0, 1'b1, 1'b0, 16'h0100, 16'hA5A5, 16'hDEAD, 3'd0, 3,  3, 4, 1'b0, 16'h0,    1'b0, 1'b1);
    vecs[3] = mkv("ld_misal",  1'b1, 1'b0, 1'b1, 16'h0003, 16'h0,    16'h1111, 3'd2, 0,  0, 0, 1'b0, 16'h0,    1'b1, 1'b0);
    vecs[4] = mkv("ld_tmo",    1'b1, 1'b0, 1'b1, 16'h0020, 16'h0,    16'h2222, 3'd6, -1, 4, 4, 1'b0, 16'h0,    1'b1, 1'b0);
    vecs[5] = mkv("ld2wait",   1'b1, 1'b0, 1'b1, 16'h0010, 16'h0,    16'h5A5A, 3'd7, 2,  2, 3, 1'b1, 16'h5A5A, 1'b0, 1'b0);
    vecs[6] = mkv("st_misal",  1'b0, 1'b1, 1'b0, 16'h0101, 16'h3C3C, 16'h4444, 3'd1, 0,  0, 0, 1'b0, 16'h0,    1'b1, 1'b0);
    vecs[7] = mkv("alu_nowr",  1'b0, 1'b0, 1'b0, 16'h9999, 16'h0,    16'h0,    3'd4, 0,  0, 0, 1'b0, 16'h0,    1'b0, 1'b0);
    for (int i = 0; i < 8; i++) apply_vec(vecs[i]);

    // ADD bypass: forward sources at 1 and 2 edges
    do_reset();
    drive_ex(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h1234, 16'h0, 3'd5);
    @(posedge clk); #1; bubble();
    @(negedge clk); #1;
    chk("add MEM_alu_out", 32'(MEM_alu_out), 32'h1234);
    chk("add MEM_reg_write", 32'(MEM_reg_write), 32'd1);
    chk("add MEM_rd", 32'(MEM_rd), 32'd5);
    @(negedge clk); #1;
    chk("add WB_wb_data", 32'(WB_wb_data), 32'h1234);
    chk("add WB_rd", 32'(WB_rd), 32'd5);
    chk("add WB_reg_write", 32'(WB_reg_write), 32'd1);

    // 3-wait store with a following ALU op held in EX/MEM input
    do_reset();
    slave_lat = 3;
    drive_ex(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0100, 16'hA5A5, 3'd0);
    @(posedge clk); #1;
    drive_ex(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h7777, 16'h0, 3'd1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      chk($sformatf("st c%0d dmem_req", c), 32'(mb.dmem_req), 32'd1);
      chk($sformatf("st c%0d dmem_wr", c), 32'(mb.dmem_wr), 32'd1);
      chk($sformatf("st c%0d dmem_addr", c), 32'(mb.dmem_addr), 32'h0100);
      chk($sformatf("st c%0d dmem_wdata", c), 32'(mb.dmem_wdata), 32'hA5A5);
      chk($sformatf("st c%0d MEM_alu_out", c), 32'(MEM_alu_out), 32'h0100);
      chk($sformatf("st c%0d stall", c), 32'(stall), (c < 3) ? 32'd1 : 32'd0);
      chk($sformatf("st c%0d WB_reg_write", c), 32'(WB_reg_write), 32'd0);
      @(posedge clk); #1;
    end
    bubble();
    @(negedge clk); #1;
    chk("st next MEM_alu_out", 32'(MEM_alu_out), 32'h7777);
    chk("st retire WB_reg_write", 32'(WB_reg_write), 32'd0);
    @(negedge clk); #1;
    chk("st next WB_reg_write", 32'(WB_reg_write), 32'd1);
    chk("st next WB_wb_data", 32'(WB_wb_data), 32'h7777);

    // Reset during BUSY, then a stray dmem_done
    do_reset();
    slave_lat = -1;
    drive_ex(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0040, 16'h0, 3'd4);
    @(posedge clk); #1; bubble();
    @(negedge clk); #1;
    chk("rstbusy c0 stall", 32'(stall), 32'd1);
    @(negedge clk); #1;
    @(negedge clk); #1;
    chk("rstbusy c2 dmem_req", 32'(mb.dmem_req), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    chk("rstbusy dmem_req", 32'(mb.dmem_req), 32'd0);
    chk("rstbusy stall", 32'(stall), 32'd0);
    chk("rstbusy MEM_reg_write", 32'(MEM_reg_write), 32'd0);
    chk("rstbusy WB_reg_write", 32'(WB_reg_write), 32'd0);
    force_done = 1'b1;
    @(negedge clk); #1;
    chk("late done stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    force_done = 1'b0;
    chk("late done WB_reg_write", 32'(WB_reg_write), 32'd0);
    chk("late done err", 32'(err), 32'd0);

    // HALT reaches MEM/WB; later loads issue no request
    do_reset();
    slave_lat = 0;
    drive_ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0, 3'd0);
    @(posedge clk); #1;
    drive_ex(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0040, 16'h0, 3'd6);
    chk("halt in EX/MEM halted", 32'(halted), 32'd0);
    @(posedge clk); #1; bubble();
    chk("halt halted", 32'(halted), 32'd1);
    @(negedge clk); #1;
    chk("halt load dmem_req", 32'(mb.dmem_req), 32'd0);
    chk("halt load stall", 32'(stall), 32'd0);
    repeat (3) @(posedge clk);
    #1 chk("halt sticky", 32'(halted), 32'd1);

    // err is sticky and suppresses later aligned accesses
    do_reset();
    slave_lat = 0;
    drive_ex(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0003, 16'h0, 3'd2);
    @(posedge clk); #1;
    drive_ex(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0040, 16'h0, 3'd3);
    @(posedge clk); #1; bubble();
    @(negedge clk); #1;
    chk("err sticky err", 32'(err), 32'd1);
    chk("err sticky dmem_req", 32'(mb.dmem_req), 32'd0);
    repeat (3) @(posedge clk);
    #1 chk("err sticky later", 32'(err), 32'd1);

    // Randomized program against a program-order model
    do_reset();
    for (int k = 0; k < 64; k++) begin
      smem[k] = 16'($urandom);
      mmem[k] = smem[k];
    end
    slave_lat = int'($urandom_range(0, 3));
    slave_rand = 1'b1;
    gen_drive();
    issued = 1;
    for (int cyc = 0; cyc < 5000 && (issued < NRAND || exp_q.size() != 0); cyc++) begin
      @(negedge clk); #1;
      consumed = !stall;
      if (WB_reg_write) begin
        if (exp_q.size() == 0) begin
          chk("rand spurious WB_reg_write", 32'd1, 32'd0);
        end else begin
          r = exp_q.pop_front();
          chk("rand WB_rd", 32'(WB_rd), 32'(r.rd));
          chk("rand WB_wb_data", 32'(WB_wb_data), 32'(r.data));
        end
      end
      @(posedge clk); #1;
      if (consumed) begin
        if (issued < NRAND) begin
          gen_drive();
          issued++;
        end else begin
          bubble();
        end
      end
    end
    chk("rand all retired", 32'(exp_q.size()), 32'd0);
    bubble();
    repeat (8) @(posedge clk);
    #1;
    for (int k = 0; k < 64; k++) chk($sformatf("rand mem[%0d]", k), 32'(smem[k]), 32'(mmem[k]));
    chk("rand err clear", 32'(err), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
